// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: nop encoding, ROM window,
// IF FSM state codes, alignment mask and the PC next-value select.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [23:0] ROM_BASE_ADDRESS = 24'd0;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    // IF FSM state codes
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Next-PC select for the PC register
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_stage_pc_register.sv
// Program counter flop with hold / increment / load select.
// Kept as its own block so a wider fetch front end can instantiate several.
module pc_register
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_e     sel,
    input  logic [31:0] load_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // Incrementer wraps modulo 2^32
    assign pc_plus4 = pc + 32'd4;

    // PC update: reset value, then load/increment/hold according to sel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_LOAD: pc <= load_value;
                PC_INC:  pc <= pc_plus4;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the ROM address from the PC, captures the
// returned word into the IF/ID register, and handles branch, flush, stall and
// fetch faults. A fault parks the stage in HALT until reset.
//
// IF/ID handshake: if_id_valid=1 means if_id_instr/if_id_pc_plus4 hold a real
// instruction for decode. There is no ready signal; the hazard unit applies
// backpressure through stall, which freezes both the PC and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [23:0] BASE_ADDRESS = ROM_BASE_ADDRESS,
    parameter logic [31:0] NOP_INSTR    = if_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [0:0]  dbg_state
);

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    pc_sel_e     pc_sel;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        target_misaligned;
    logic        in_window;

    logic [31:0] instr_nxt;
    logic [31:0] pc_plus4_nxt;
    logic        valid_nxt;
    logic        fault_nxt;

    assign rom_address       = pc;
    assign dbg_state         = state;
    assign target_aligned    = word_align(branch_target);
    assign target_misaligned = (branch_target[1:0] != 2'b00);
    assign in_window         = (pc[31:8] == BASE_ADDRESS);

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .sel        (pc_sel),
        .load_value (target_aligned),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    // Next-state decode: branch > flush > stall > advance while running; HALT squashes
    always_comb begin
        pc_sel       = PC_HOLD;
        instr_nxt    = if_id_instr;
        pc_plus4_nxt = if_id_pc_plus4;
        valid_nxt    = if_id_valid;
        fault_nxt    = fetch_fault;
        state_nxt    = state;

        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect always lands on a word boundary; a misaligned
                    // request is still recorded as a fault and stops fetch.
                    pc_sel    = PC_LOAD;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    if (target_misaligned) begin
                        fault_nxt = 1'b1;
                        state_nxt = ST_HALT;
                    end
                end else if (flush) begin
                    pc_sel    = PC_INC;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    pc_sel = PC_HOLD;
                end else if (!in_window) begin
                    // Out-of-window fetch: PC stays at the faulting address
                    pc_sel    = PC_HOLD;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    pc_sel       = PC_INC;
                    instr_nxt    = rom_data;
                    pc_plus4_nxt = pc_plus4;
                    valid_nxt    = 1'b1;
                end
            end
            default: begin
                pc_sel    = PC_HOLD;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // IF/ID register, sticky fault flag and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
            state          <= ST_RUN;
        end else begin
            if_id_instr    <= instr_nxt;
            if_id_pc_plus4 <= pc_plus4_nxt;
            if_id_valid    <= valid_nxt;
            fetch_fault    <= fault_nxt;
            state          <= state_nxt;
        end
    end

endmodule
